// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX/MEM observation inputs and pipeline control outputs.
// The master modport drives the pipeline side; the slave modport is the controller.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       i_id_Rs1;
    logic [4:0]       i_id_Rs2;
    logic             i_id_UsesRs1;
    logic             i_id_UsesRs2;
    logic [4:0]       i_ex_RegDst;
    logic             i_ex_MemToReg;
    logic             i_ex_RegWrEn;
    logic             i_mem_Branch;
    logic             i_mem_Jump;
    logic             i_mem_Zero;
    logic [31:0]      i_mem_TargetAddr;
    logic             i_ext_Hold;
    logic             o_PcWrEn;
    logic             o_PcSel;
    logic [31:0]      o_PcTarget;
    logic             o_IfIdWrEn;
    logic             o_IfIdFlush;
    logic             o_IdExFlush;
    logic             o_ExMemFlush;
    logic [1:0]       o_State;
    logic [CNT_W-1:0] o_StallCycles;
    logic [CNT_W-1:0] o_FlushEvents;

    modport master (
        output i_id_Rs1, i_id_Rs2, i_id_UsesRs1, i_id_UsesRs2,
        output i_ex_RegDst, i_ex_MemToReg, i_ex_RegWrEn,
        output i_mem_Branch, i_mem_Jump, i_mem_Zero, i_mem_TargetAddr, i_ext_Hold,
        input  o_PcWrEn, o_PcSel, o_PcTarget, o_IfIdWrEn, o_IfIdFlush,
        input  o_IdExFlush, o_ExMemFlush, o_State, o_StallCycles, o_FlushEvents
    );

    modport slave (
        input  i_id_Rs1, i_id_Rs2, i_id_UsesRs1, i_id_UsesRs2,
        input  i_ex_RegDst, i_ex_MemToReg, i_ex_RegWrEn,
        input  i_mem_Branch, i_mem_Jump, i_mem_Zero, i_mem_TargetAddr, i_ext_Hold,
        output o_PcWrEn, o_PcSel, o_PcTarget, o_IfIdWrEn, o_IfIdFlush,
        output o_IdExFlush, o_ExMemFlush, o_State, o_StallCycles, o_FlushEvents
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for light_rv32i: load-use bubble, branch/jump redirect, external hold.
// Define PIPE_HAZARD_CTRL_PERF_EN to build the stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int unsigned CD_W = 2;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_STALL    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [CD_W-1:0] r_cnt;
    logic [CD_W-1:0] w_next_cnt;
    logic [31:0]     r_target;
    logic [31:0]     w_next_target;
    logic            w_taken;
    logic            w_loaduse;
    logic            w_first;
    logic            w_pc_wr;
    logic            w_pc_sel;
    logic            w_ifid_wr;
    logic            w_ifid_fl;
    logic            w_idex_fl;
    logic            w_exmem_fl;

    assign w_taken   = bus.i_mem_Jump | (bus.i_mem_Branch & bus.i_mem_Zero);
    assign w_loaduse = bus.i_ex_MemToReg & bus.i_ex_RegWrEn & (bus.i_ex_RegDst != 5'd0) &
                       ((bus.i_id_UsesRs1 & (bus.i_id_Rs1 == bus.i_ex_RegDst)) |
                        (bus.i_id_UsesRs2 & (bus.i_id_Rs2 == bus.i_ex_RegDst)));
    assign w_first   = (r_cnt == CD_W'(FLUSH_CYCLES));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_RUN;
            r_cnt    <= '0;
            r_target <= '0;
        end else begin
            r_state  <= w_next_state;
            r_cnt    <= w_next_cnt;
            r_target <= w_next_target;
        end
    end

    // Next state and pipeline controls; hold freezes everything and outranks redirect/bubble.
    always_comb begin
        w_next_state  = r_state;
        w_next_cnt    = r_cnt;
        w_next_target = r_target;
        w_pc_wr       = 1'b1;
        w_pc_sel      = 1'b0;
        w_ifid_wr     = 1'b1;
        w_ifid_fl     = 1'b0;
        w_idex_fl     = 1'b0;
        w_exmem_fl    = 1'b0;
        if (!reset_n || bus.i_ext_Hold) begin
            w_pc_wr   = 1'b0;
            w_ifid_wr = 1'b0;
        end else begin
            case (r_state)
                ST_RUN, ST_STALL: begin
                    if (w_taken) begin
                        w_pc_wr       = 1'b0;
                        w_ifid_fl     = 1'b1;
                        w_idex_fl     = 1'b1;
                        w_exmem_fl    = 1'b1;
                        w_next_target = bus.i_mem_TargetAddr;
                        w_next_cnt    = CD_W'(FLUSH_CYCLES);
                        w_next_state  = ST_REDIRECT;
                    end else if (r_state == ST_RUN && w_loaduse) begin
                        w_pc_wr      = 1'b0;
                        w_ifid_wr    = 1'b0;
                        w_idex_fl    = 1'b1;
                        w_next_state = ST_STALL;
                    end else begin
                        w_next_state = ST_RUN;
                    end
                end
                ST_REDIRECT: begin
                    if (w_first) begin
                        w_pc_sel  = 1'b1;
                        w_ifid_fl = 1'b1;
                        w_idex_fl = 1'b1;
                    end else begin
                        w_pc_wr   = 1'b0;
                        w_ifid_fl = 1'b1;
                    end
                    w_next_cnt = r_cnt - CD_W'(1);
                    if (r_cnt == CD_W'(1)) begin
                        w_next_state = ST_RUN;
                    end
                end
                default: w_next_state = ST_RUN;
            endcase
        end
    end

    assign bus.o_PcWrEn     = w_pc_wr;
    assign bus.o_PcSel      = w_pc_sel;
    assign bus.o_PcTarget   = r_target;
    assign bus.o_IfIdWrEn   = w_ifid_wr;
    assign bus.o_IfIdFlush  = w_ifid_fl;
    assign bus.o_IdExFlush  = w_idex_fl;
    assign bus.o_ExMemFlush = w_exmem_fl;
    assign bus.o_State      = 2'(r_state);

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_stall_evt;
    logic             w_flush_evt;

    // Redirect cycles do not count as stalls; only hold and the load-use bubble do.
    assign w_stall_evt = bus.i_ext_Hold | ((r_state == ST_RUN) & ~w_taken & w_loaduse);
    assign w_flush_evt = ~bus.i_ext_Hold & (r_state != ST_REDIRECT) & w_taken;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush_evt && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.o_StallCycles = r_stall_cnt;
    assign bus.o_FlushEvents = r_flush_cnt;
`else
    assign bus.o_StallCycles = '0;
    assign bus.o_FlushEvents = '0;
`endif
endmodule
